// File: rtl/btn_filter_pkg.sv
// Shared definitions for the multi-channel button filter.
//   btn_state_t : per-channel debounce FSM state encoding (2 bits).
//   clog2       : counter width helper, returns at least 1.
package btn_filter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DB_PRESS = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_DB_REL   = 2'd3
    } btn_state_t;

    // Bits needed to hold values 0..value-1; never returns 0 so it can size a vector.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/btn_filter_ch.sv
// One button channel: 2-flop synchroniser, symmetric press/release debounce
// FSM and a saturating hold timer that raises a long-press flag.
// Ports:
//   i_clk_32k        always-on clock
//   i_rst            synchronous active-high reset
//   i_btn            raw asynchronous pin
//   i_arm            0 holds the FSM in IDLE with counters cleared
//   o_act            synchronised, polarity-corrected pressed sample
//   o_state          current FSM state (debug observation)
//   o_pressed        debounced pressed level
//   o_press_pulse    1-cycle pulse on accepted press
//   o_release_pulse  1-cycle pulse on accepted release
//   o_long           long-press level
//   o_long_pulse     1-cycle pulse when o_long sets
module btn_filter_ch
    import btn_filter_pkg::*;
#(
    parameter int ACTIVE_LOW = 1,
    parameter int DEB_CYC    = 32,
    parameter int LONG_CYC   = 131072
) (
    input  logic       i_clk_32k,
    input  logic       i_rst,
    input  logic       i_btn,
    input  logic       i_arm,
    output logic       o_act,
    output btn_state_t o_state,
    output logic       o_pressed,
    output logic       o_press_pulse,
    output logic       o_release_pulse,
    output logic       o_long,
    output logic       o_long_pulse
);

    localparam int DW = clog2(DEB_CYC + 1);
    localparam int HW = clog2(LONG_CYC + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYC);
    // Pin level when the button is not pressed.
    localparam logic INACTIVE = (ACTIVE_LOW != 0);

    logic          r_sync1;
    logic          r_sync2;
    btn_state_t    r_state;
    logic [DW-1:0] r_deb;
    logic [HW-1:0] r_hold;
    logic          r_pressed;
    logic          r_press_pulse;
    logic          r_release_pulse;
    logic          r_long;
    logic          r_long_pulse;

    logic          w_act;
    logic [HW-1:0] w_hold_next;
    logic          w_long_hit;

    // The synchroniser is never gated by i_arm: the arm logic needs o_act.
    always_ff @(posedge i_clk_32k) begin
        if (i_rst) begin
            r_sync1 <= INACTIVE;
            r_sync2 <= INACTIVE;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    assign w_act       = r_sync2 ^ INACTIVE;
    // Saturating at LONG_CYC means the threshold compare matches only once per press.
    assign w_hold_next = (r_hold == HOLD_MAX) ? r_hold : r_hold + 1'b1;
    assign w_long_hit  = (r_hold == HOLD_LAST) && !r_long;

    always_ff @(posedge i_clk_32k) begin
        if (i_rst || !i_arm) begin
            r_state         <= ST_IDLE;
            r_deb           <= '0;
            r_hold          <= '0;
            r_pressed       <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long          <= 1'b0;
            r_long_pulse    <= 1'b0;
        end else begin
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_act) begin
                        if (DEB_CYC == 1) begin
                            r_state       <= ST_PRESSED;
                            r_pressed     <= 1'b1;
                            r_press_pulse <= 1'b1;
                            r_hold        <= '0;
                        end else begin
                            r_state <= ST_DB_PRESS;
                            r_deb   <= DW'(1);
                        end
                    end
                end
                ST_DB_PRESS: begin
                    if (!w_act) begin
                        r_state <= ST_IDLE;
                        r_deb   <= '0;
                    end else if (r_deb == DEB_LAST) begin
                        r_state       <= ST_PRESSED;
                        r_deb         <= '0;
                        r_pressed     <= 1'b1;
                        r_press_pulse <= 1'b1;
                        r_hold        <= '0;
                    end else begin
                        r_deb <= r_deb + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!w_act && (DEB_CYC == 1)) begin
                        // Single-sample debounce: release is accepted immediately.
                        r_state         <= ST_IDLE;
                        r_deb           <= '0;
                        r_hold          <= '0;
                        r_pressed       <= 1'b0;
                        r_long          <= 1'b0;
                        r_release_pulse <= 1'b1;
                    end else begin
                        r_hold <= w_hold_next;
                        if (w_long_hit) begin
                            r_long       <= 1'b1;
                            r_long_pulse <= 1'b1;
                        end
                        if (!w_act) begin
                            r_state <= ST_DB_REL;
                            r_deb   <= DW'(1);
                        end
                    end
                end
                ST_DB_REL: begin
                    if (!w_act && (r_deb == DEB_LAST)) begin
                        // Accepted release wins over a coincident long threshold.
                        r_state         <= ST_IDLE;
                        r_deb           <= '0;
                        r_hold          <= '0;
                        r_pressed       <= 1'b0;
                        r_long          <= 1'b0;
                        r_release_pulse <= 1'b1;
                    end else begin
                        // Release bounces do not restart the hold timer.
                        r_hold <= w_hold_next;
                        if (w_long_hit) begin
                            r_long       <= 1'b1;
                            r_long_pulse <= 1'b1;
                        end
                        if (w_act) begin
                            r_state <= ST_PRESSED;
                            r_deb   <= '0;
                        end else begin
                            r_deb <= r_deb + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_act           = w_act;
    assign o_state         = r_state;
    assign o_pressed       = r_pressed;
    assign o_press_pulse   = r_press_pulse;
    assign o_release_pulse = r_release_pulse;
    assign o_long          = r_long;
    assign o_long_pulse    = r_long_pulse;

endmodule

// File: rtl/btn_filter_mc.sv
// Multi-channel button filter for the always-on 32 kHz domain. Each pin gets
// its own btn_filter_ch; this level adds the global arm gate, which only rises
// after every button has been released for ARM_CYC consecutive cycles.
// Ports:
//   i_clk_32k        32.768 kHz always-on clock
//   i_rst            synchronous active-high reset
//   i_btn            raw asynchronous button pins
//   o_arm            block armed, sticky until reset
//   o_pressed        debounced pressed level per channel
//   o_press_pulse    1-cycle pulse on accepted press
//   o_release_pulse  1-cycle pulse on accepted release
//   o_long           long-press level per channel
//   o_long_pulse     1-cycle pulse when o_long sets
//   o_dbg_state      per-channel FSM state, 2 bits per channel (channel i at [2i+1:2i])
module btn_filter_mc
    import btn_filter_pkg::*;
#(
    parameter int CH_NUM     = 4,
    parameter int ACTIVE_LOW = 1,
    parameter int DEB_CYC    = 32,
    parameter int LONG_CYC   = 131072,
    parameter int ARM_CYC    = 1023
) (
    input  logic                  i_clk_32k,
    input  logic                  i_rst,
    input  logic [CH_NUM-1:0]     i_btn,
    output logic                  o_arm,
    output logic [CH_NUM-1:0]     o_pressed,
    output logic [CH_NUM-1:0]     o_press_pulse,
    output logic [CH_NUM-1:0]     o_release_pulse,
    output logic [CH_NUM-1:0]     o_long,
    output logic [CH_NUM-1:0]     o_long_pulse,
    output logic [2*CH_NUM-1:0]   o_dbg_state
);

    if (CH_NUM < 1 || CH_NUM > 16) begin : g_bad_ch_num
        $error("btn_filter_mc: CH_NUM must be 1..16");
    end
    if (!(LONG_CYC > DEB_CYC && DEB_CYC >= 1)) begin : g_bad_deb
        $error("btn_filter_mc: need LONG_CYC > DEB_CYC >= 1");
    end
    if (ARM_CYC < 1) begin : g_bad_arm
        $error("btn_filter_mc: ARM_CYC must be >= 1");
    end

    localparam int AW = clog2(ARM_CYC + 1);
    localparam logic [AW-1:0] ARM_LAST = AW'(ARM_CYC - 1);

    logic [CH_NUM-1:0] w_act;
    btn_state_t        w_state [CH_NUM];
    logic              w_any_act;
    logic [AW-1:0]     r_arm_cnt;
    logic              r_arm;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        btn_filter_ch #(
            .ACTIVE_LOW (ACTIVE_LOW),
            .DEB_CYC    (DEB_CYC),
            .LONG_CYC   (LONG_CYC)
        ) u_ch (
            .i_clk_32k       (i_clk_32k),
            .i_rst           (i_rst),
            .i_btn           (i_btn[g]),
            .i_arm           (r_arm),
            .o_act           (w_act[g]),
            .o_state         (w_state[g]),
            .o_pressed       (o_pressed[g]),
            .o_press_pulse   (o_press_pulse[g]),
            .o_release_pulse (o_release_pulse[g]),
            .o_long          (o_long[g]),
            .o_long_pulse    (o_long_pulse[g])
        );
        assign o_dbg_state[2*g +: 2] = w_state[g];
    end

    assign w_any_act = |w_act;

    // Counter freezes once armed; arm never drops until reset.
    always_ff @(posedge i_clk_32k) begin
        if (i_rst) begin
            r_arm_cnt <= '0;
            r_arm     <= 1'b0;
        end else if (!r_arm) begin
            if (w_any_act) begin
                r_arm_cnt <= '0;
            end else if (r_arm_cnt == ARM_LAST) begin
                r_arm <= 1'b1;
            end else begin
                r_arm_cnt <= r_arm_cnt + 1'b1;
            end
        end
    end

    assign o_arm = r_arm;

endmodule
